// File: rtl/day2_rr_arb2.sv
// Two-channel round-robin arbiter feeding a one-deep registered valid/ready output stage.
// Drives the day1_mux select (1=A, 0=B) and keeps per-channel transfer counters for debug.
module day2_rr_arb2 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              sel,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_src,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  logic space_c;
  logic grant_a_c;
  logic grant_b_c;
  logic prio_a;
  logic sel_q;

  // Grant is only evaluated when the output register can take a word this cycle.
  always_comb begin
    space_c   = !y_valid || y_ready;
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (space_c) begin
      if (a_valid && b_valid) begin
        grant_a_c = prio_a;
        grant_b_c = !prio_a;
      end else begin
        grant_a_c = a_valid;
        grant_b_c = b_valid;
      end
    end
  end

  // Outputs held low during reset; sel keeps its last grant when nothing is granted.
  always_comb begin
    a_ready = rst_n && grant_a_c;
    b_ready = rst_n && grant_b_c;
    sel     = 1'b0;
    if (rst_n) begin
      sel = (grant_a_c || grant_b_c) ? grant_a_c : sel_q;
    end
  end

  // Output register, round-robin priority and transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_src   <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      prio_a  <= 1'b1;
      sel_q   <= 1'b1;
    end else if (grant_a_c || grant_b_c) begin
      y_valid <= 1'b1;
      y_data  <= grant_a_c ? a_data : b_data;
      y_src   <= grant_a_c;
      prio_a  <= grant_b_c;
      sel_q   <= grant_a_c;
      if (grant_a_c) begin
        cnt_a <= cnt_a + CNT_W'(1);
      end
      if (grant_b_c) begin
        cnt_b <= cnt_b + CNT_W'(1);
      end
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_day2_rr_arb2.sv
// Directed bench for day2_rr_arb2: stimulus pushes expected output words into a
// scoreboard queue, a monitor pops and compares on every output handshake.
module tb_day2_rr_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, y_valid, y_src;
  logic [7:0] y_data, cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];   // {src, data}

  always #5 clk = ~clk;

  day2_rr_arb2 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .sel(sel),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_src(y_src),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word presented with y_ready high is popped at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {23'd0, y_src, y_data}, 32'h1ff);
        end else begin
          chk("y_word", {23'd0, y_src, y_data}, {23'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    // Watchdog so the bench always ends.
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_a;
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data = 8'h11; b_data = 8'h22;

    // 1: reset with both valid
    cyc(); #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    rst_n = 1'b1; #1;
    chk("first_tie_a_ready", a_ready, 1);
    chk("first_tie_b_ready", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("idle_sel_after_reset", sel, 1);

    // 2: single A transfer
    cyc();
    a_valid = 1'b1; a_data = 8'h3C; #1;
    chk("t2_a_ready", a_ready, 1);
    chk("t2_b_ready", b_ready, 0);
    chk("t2_sel", sel, 1);
    sb.push_back({1'b1, 8'h3C});
    cyc();
    a_valid = 1'b0;
    chk("t2_y_valid", y_valid, 1);
    chk("t2_y_data", y_data, 8'h3C);
    chk("t2_y_src", y_src, 1);
    chk("t2_cnt_a", cnt_a, 1);
    cyc();
    chk("t2_popped", y_valid, 0);
    rst_n = 1'b0; #2; rst_n = 1'b1;

    // 3: sustained tie alternates A,B,A,B,A,B
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA5; b_data = 8'h5A;
    exp_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_a_ready", a_ready, exp_a);
      chk("t3_b_ready", b_ready, !exp_a);
      sb.push_back({exp_a, exp_a ? 8'hA5 : 8'h5A});
      cyc();
      exp_a = !exp_a;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_cnt_a", cnt_a, 3);
    chk("t3_cnt_b", cnt_b, 3);
    cyc();

    // 4: stall holds everything, release pops and loads in one cycle
    y_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hC1; b_data = 8'hD2; #1;
    chk("t4_load_a_ready", a_ready, 1);
    sb.push_back({1'b1, 8'hC1});
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_a_ready", a_ready, 0);
      chk("t4_stall_b_ready", b_ready, 0);
      chk("t4_stall_y_valid", y_valid, 1);
      chk("t4_stall_y_data", y_data, 8'hC1);
      chk("t4_stall_cnt_a", cnt_a, 4);
      cyc();
    end
    y_ready = 1'b1; #1;
    chk("t4_release_a_ready", a_ready, 0);
    chk("t4_release_b_ready", b_ready, 1);
    chk("t4_release_sel", sel, 0);
    sb.push_back({1'b0, 8'hD2});
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t4_reload_y_valid", y_valid, 1);
    chk("t4_reload_y_data", y_data, 8'hD2);
    chk("t4_cnt_b", cnt_b, 4);
    cyc();
    rst_n = 1'b0; #2; rst_n = 1'b1;

    // 5: 256 A-only transfers wrap cnt_a
    a_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_data = 8'(i);
      sb.push_back({1'b1, 8'(i)});
      cyc();
      if (i == 254) chk("t5_cnt_a_max", cnt_a, 8'hFF);
    end
    a_valid = 1'b0;
    chk("t5_cnt_a_wrap", cnt_a, 0);
    chk("t5_cnt_b", cnt_b, 0);
    cyc();

    // 6: async reset mid-stall drops the held word
    y_ready = 1'b0; a_valid = 1'b1; a_data = 8'h77; b_data = 8'h88; #1;
    sb.push_back({1'b1, 8'h77});
    cyc();
    b_valid = 1'b1;
    chk("t6_held", y_valid, 1);
    rst_n = 1'b0; #1;
    chk("t6_async_y_valid", y_valid, 0);
    chk("t6_async_a_ready", a_ready, 0);
    chk("t6_async_b_ready", b_ready, 0);
    chk("t6_async_cnt_a", cnt_a, 0);
    void'(sb.pop_back());
    #1; rst_n = 1'b1; y_ready = 1'b1; #1;
    chk("t6_tie_a_ready", a_ready, 1);
    chk("t6_tie_b_ready", b_ready, 0);
    sb.push_back({1'b1, 8'h77});
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
